// File: rtl/seq_decoder_pkg.sv
// ---------------------------------------------------------------------------------------------
// seq_decoder_pkg
//   Shared definitions for the sequencing one-hot decoder: mode encodings and a helper that
//   sizes the scan prescaler counter.
//
//   Contents:
//     mode_t          2-bit mode code carried on the controller bus
//     MODE_DECODE     00  index only changes on a load
//     MODE_SCAN_UP    01  index steps +1 every DIV cycles
//     MODE_SCAN_DOWN  10  index steps -1 every DIV cycles
//     MODE_HOLD       11  index and prescaler frozen
//     cnt_width()     prescaler width, max(1, $clog2(div))
// ---------------------------------------------------------------------------------------------
package seq_decoder_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DECODE    = 2'b00;
  localparam mode_t MODE_SCAN_UP   = 2'b01;
  localparam mode_t MODE_SCAN_DOWN = 2'b10;
  localparam mode_t MODE_HOLD      = 2'b11;

  // DIV of 1 or 2 still needs a one-bit counter so the compare logic stays uniform.
  function automatic int unsigned cnt_width(int unsigned div);
    int unsigned w;
    w = $clog2(div);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_decoder_if.sv
// ---------------------------------------------------------------------------------------------
// seq_decoder_if
//   Bundle between a controller and the sequencing decoder.
//
//   Signals:
//     en    controller -> decoder  output enable (index keeps running when low)
//     mode  controller -> decoder  DECODE / SCAN_UP / SCAN_DOWN / HOLD
//     ld    controller -> decoder  load strobe, copies sel into the index
//     sel   controller -> decoder  select value used by ld
//     out   decoder -> loads       registered one-hot of the index, width 2^N
//     idx   decoder -> controller  current index
//     vld   decoder -> controller  registered copy of en
//     wrap  decoder -> controller  one-cycle pulse when a scan wraps
//
//   Modports: master (controller side), slave (decoder side).
// ---------------------------------------------------------------------------------------------
interface seq_decoder_if #(
  parameter int unsigned N = 3
) ();

  import seq_decoder_pkg::*;

  logic              en;
  mode_t             mode;
  logic              ld;
  logic [N-1:0]      sel;
  logic [(1<<N)-1:0] out;
  logic [N-1:0]      idx;
  logic              vld;
  logic              wrap;

  modport master (
    output en,
    output mode,
    output ld,
    output sel,
    input  out,
    input  idx,
    input  vld,
    input  wrap
  );

  modport slave (
    input  en,
    input  mode,
    input  ld,
    input  sel,
    output out,
    output idx,
    output vld,
    output wrap
  );

endinterface

// File: rtl/step_div.sv
// ---------------------------------------------------------------------------------------------
// step_div
//   Scan prescaler. Counts 0..DIV-1 while run is high and flags the terminal count so the
//   owner can step its index; the counter then restarts from 0. clr has priority and forces
//   the count back to 0; with neither clr nor run the count is frozen.
//
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-high reset, count -> 0
//     clr   synchronous clear of the count
//     run   advance the count this cycle
//     tick  high while run is set and the count sits at DIV-1 (step edge)
//
//   DIV must be at least 1; DIV=1 makes tick follow run every cycle.
// ---------------------------------------------------------------------------------------------
module step_div
  import seq_decoder_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned     CntW   = cnt_width(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = run && !clr && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seq_decoder.sv
// ---------------------------------------------------------------------------------------------
// seq_decoder
//   Registered N-to-2^N one-hot decoder with a built-in index sequencer. The index can be
//   loaded directly, held, or stepped up/down once every DIV cycles; the one-hot output is
//   the registered decode of the next index, gated by en.
//
//   Ports:
//     clk   clock, rising edge
//     rst   asynchronous active-high reset (idx, out, vld, wrap -> 0, mode history -> DECODE)
//     bus   seq_decoder_if slave: en/mode/ld/sel in, out/idx/vld/wrap out
//
//   Index priority, highest first: ld, then a change of mode (prescaler restarts, index
//   kept), then the behaviour of the current mode.
// ---------------------------------------------------------------------------------------------
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int unsigned N   = 3,
  parameter int unsigned DIV = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_decoder_if.slave  bus
);

  localparam int unsigned  OutW    = 1 << N;
  localparam logic [N-1:0] IdxLast = {N{1'b1}};

  logic [N-1:0]    idx_q, idx_d;
  logic [OutW-1:0] out_q, out_d;
  logic            vld_q;
  logic            wrap_q, wrap_d;
  mode_t           mode_q;

  logic mode_chg;
  logic is_scan;
  logic pre_clr;
  logic pre_run;
  logic tick;

  // Prescaler control. DECODE keeps the count parked at 0; HOLD neither clears nor runs it,
  // so a scan resumed from HOLD without a mode change would continue the old phase -- but any
  // return from HOLD is itself a mode change, which restarts the phase.
  always_comb begin
    mode_chg = (bus.mode != mode_q);
    is_scan  = (bus.mode == MODE_SCAN_UP) || (bus.mode == MODE_SCAN_DOWN);
    pre_clr  = bus.ld || mode_chg || (bus.mode == MODE_DECODE);
    pre_run  = is_scan && !bus.ld && !mode_chg;
  end

  step_div #(
    .DIV (DIV)
  ) u_step_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .run  (pre_run),
    .tick (tick)
  );

  // Next index, wrap flag and one-hot. tick is only ever raised in a scan mode without ld,
  // so a load on a step edge wins and suppresses wrap automatically.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (bus.ld) begin
      idx_d = bus.sel;
    end else if (tick) begin
      unique case (bus.mode)
        MODE_SCAN_UP: begin
          idx_d  = idx_q + N'(1);
          wrap_d = (idx_q == IdxLast);
        end
        MODE_SCAN_DOWN: begin
          idx_d  = idx_q - N'(1);
          wrap_d = (idx_q == '0);
        end
        default: begin
          idx_d  = idx_q;
          wrap_d = 1'b0;
        end
      endcase
    end
    out_d = bus.en ? (OutW'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      wrap_q <= 1'b0;
      mode_q <= MODE_DECODE;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      vld_q  <= bus.en;
      wrap_q <= wrap_d;
      mode_q <= bus.mode;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.vld  = vld_q;
  assign bus.wrap = wrap_q;

endmodule

// File: doc/seq_decoder.md
# seq_decoder

Parametrised, registered N-to-2^N one-hot decoder with a built-in index sequencer. It replaces the fixed 3-to-8 combinational decoder wherever a select line must be held, scanned, or stepped over time. Typical uses are row/column strobing, display multiplexing and round-robin enable generation. The block sits between a controller that supplies a select value or mode and the downstream loads that consume one-hot enables.

## Interface
Parameters:
- N, 3: select width; output width is 2^N.
- DIV, 4: clock cycles per scan step; legal range is ≥1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- en, input, 1: output enable; when 0, out is forced to all-zero (the index still runs).
- mode, input, 2: 00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
- ld, input, 1: load strobe; copies sel into the index.
- sel, input, N: select value used by ld.
- out, output, 2^N: registered one-hot decode of the index.
- idx, output, N: current index.
- vld, output, 1: registered copy of en; out is meaningful when 1.
- wrap, output, 1: one-cycle pulse when a scan wraps around.

## Operation
- Reset values (asynchronous): idx=0, prescaler=0, out=0, vld=0, wrap=0. The last mode is recorded as DECODE.
- The next index (idx_n) is computed from the priority rules below. On each edge: idx<=idx_n, out<=en ? (1<<idx_n) : 0, vld<=en.
- Priority, highest first: ld, then mode change, then mode behaviour.
- ld=1 (any mode): idx_n=sel, prescaler cleared, wrap=0.
- Mode change: if mode differs from the previous cycle's mode, the prescaler is cleared and idx is unchanged that cycle.
- DECODE: idx is unchanged without ld, and the prescaler is held at 0.
- SCAN_UP: the prescaler counts 0..DIV-1. At DIV-1 it returns to 0 and idx increments.
  - Going from 2^N-1 to 0 sets wrap=1 for exactly that cycle.
- SCAN_DOWN: same as SCAN_UP but idx decrements. Going from 0 to 2^N-1 sets wrap.
- HOLD: idx and prescaler are frozen, and wrap=0.
- DIV=1: the index steps every cycle in scan modes.
- Width rules: idx arithmetic is modulo 2^N. The prescaler is max(1,$clog2(DIV)) bits wide. out always has at most one bit set.

## Timing
- Load latency: ld sampled high at edge k gives idx=sel and out=onehot(sel) (if en) after edge k. That is one cycle from strobe to output.
- Scan cadence: after entering SCAN_UP at edge k (prescaler cleared), the first step occurs at edge k+DIV, then every DIV edges.
- en change is visible on out and vld after the next edge. Toggling en never disturbs idx or the prescaler.
- wrap is high in the same cycle that out shows the wrapped index.
- Reset asserted mid-scan clears all state immediately, with no clock required. Scanning resumes from idx=0 only when mode is SCAN_* and rst is low. The first step follows DIV edges after reset release.
- ld asserted on a step edge: the load wins, no increment occurs, and wrap is not raised.

## Structure
- Shared package seq_decoder_pkg holds the mode encodings MODE_DECODE, MODE_SCAN_UP, MODE_SCAN_DOWN and MODE_HOLD as 2-bit localparams or an enum.
- One sub-module, step_div, is the DIV prescaler. It takes clk, rst, clr and run, and outputs tick, asserted on the DIV-1 count.
- Index register, one-hot encoder and wrap logic stay in the top level.

## Test plan
All scenarios use N=3 and DIV=4.
- Reset and decode: assert rst, then release. With mode=DECODE, en=1, pulse ld with sel=5 → out=8'b0010_0000, idx=5, vld=1 one cycle after the ld edge. Exhaustively sweep sel 0..7 with the expected one-hot each time.
- Scan-up wrap: ld sel=6, then mode=SCAN_UP → idx goes 6→7→0→1 with steps exactly 4 cycles apart. wrap is high for one cycle, only when idx becomes 0.
- Scan-down and HOLD: from idx=1, run SCAN_DOWN → 0 then 7 with wrap. Switch to HOLD for 10 cycles → idx stays 7 and out stays 8'b1000_0000. Return to SCAN_DOWN → next step occurs 4 cycles later.
- Enable gating: mid-scan set en=0 → out=0 and vld=0 next cycle while idx keeps stepping. Set en=1 → out matches the current idx.
- Collisions: assert ld with sel=3 on the same edge as a scheduled step from 7 → idx=3, wrap=0. Assert rst asynchronously between edges mid-scan → all outputs go to 0 at once.
- DIV=1 variant: SCAN_UP from 0 → idx increments every cycle, and wrap pulses every 8 cycles.
